// File: rtl/booth_mult.sv
// Sequential radix-2 Booth signed multiplier, N x N -> 2N, one Booth step per clock.
// Define BOOTH_OVF_EN to add the ovf output (product not representable in N signed bits).
module booth_mult #(
    parameter int N = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     multiplicand,
    input  logic [N-1:0]     multiplier,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   product
`ifdef BOOTH_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q;
    logic [N:0]      mx_q;
    logic [N:0]      a_q;
    logic [N-1:0]    q_q;
    logic            q1_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;
    logic            done_q;
    logic [2*N-1:0]  product_q;

    logic [N:0]      a_sum;
    logic [N:0]      a_d;
    logic [N-1:0]    q_d;
    logic            q1_d;
    logic [2*N-1:0]  product_d;

    // A carries one guard bit so subtracting the most negative M stays exact.
    always_comb begin
        a_sum = a_q;
        case ({q_q[0], q1_q})
            2'b01:   a_sum = a_q + mx_q;
            2'b10:   a_sum = a_q - mx_q;
            default: a_sum = a_q;
        endcase
        a_d       = {a_sum[N], a_sum[N:1]};
        q_d       = {a_sum[0], q_q[N-1:1]};
        q1_d      = q_q[0];
        product_d = {a_d[N-1:0], q_d};
    end

`ifdef BOOTH_OVF_EN
    logic ovf_q;
    logic ovf_d;
    assign ovf_d = (|product_d[2*N-1:N-1]) & ~(&product_d[2*N-1:N-1]);
    assign ovf   = ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mx_q      <= '0;
            a_q       <= '0;
            q_q       <= '0;
            q1_q      <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
`ifdef BOOTH_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mx_q    <= {multiplicand[N-1], multiplicand};
                        a_q     <= '0;
                        q_q     <= multiplier;
                        q1_q    <= 1'b0;
                        cnt_q   <= CW'(N);
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q   <= a_d;
                    q_q   <= q_d;
                    q1_q  <= q1_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        product_q <= product_d;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
`ifdef BOOTH_OVF_EN
                        ovf_q     <= ovf_d;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;
endmodule

// File: tb/tb_booth_mult.sv
// Self-checking bench for booth_mult: cycle-level reference model plus directed literal checks.
module tb_booth_mult;
    localparam int N = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [N-1:0]    mc;
    logic [N-1:0]    mp;
    logic            busy;
    logic            done;
    logic [2*N-1:0]  product;
`ifdef BOOTH_OVF_EN
    logic            ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    booth_mult #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (mc),
        .multiplier   (mp),
        .busy         (busy),
        .done         (done),
        .product      (product)
`ifdef BOOTH_OVF_EN
        ,
        .ovf          (ovf)
`endif
    );

    function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        logic signed [2*N-1:0] sa;
        logic signed [2*N-1:0] sb;
        sa = {{N{a[N-1]}}, a};
        sb = {{N{b[N-1]}}, b};
        return sa * sb;
    endfunction

    function automatic logic ref_ovf(input logic [2*N-1:0] p);
        logic signed [2*N-1:0] lo;
        lo = {{N{p[N-1]}}, p[N-1:0]};
        return lo != p;
    endfunction

    task automatic chk(input string name, input logic [2*N-1:0] act, input logic [2*N-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: an accepted operation completes N edges later with the true signed product.
    logic            m_busy;
    logic            m_done;
    logic [2*N-1:0]  m_prod;
    logic [2*N-1:0]  m_pend;
    int              m_rem;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_prod <= '0;
            m_pend <= '0;
            m_rem  <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_busy <= 1'b1;
                    m_rem  <= N;
                    m_pend <= ref_mul(mc, mp);
                end
            end else if (m_rem == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_prod <= m_pend;
            end else begin
                m_rem <= m_rem - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("product", product, m_prod);
            if (busy === 1'b1 && done === 1'b1) chk("busy_and_done", 1, 0);
`ifdef BOOTH_OVF_EN
            chk("ovf", ovf, ref_ovf(m_prod));
`endif
        end
    end

    // Called just after the negedge following the accept edge; counts negedges until done.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < 3 * N) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [2*N-1:0] exp, input logic exp_ovf, input string name);
        int cyc;
        start = 1'b1;
        mc    = a;
        mp    = b;
        @(negedge clk);
        start = 1'b0;
        mc    = $urandom;
        mp    = $urandom;
        wait_done(cyc);
        chk({name, "_lat"}, cyc, N + 1);
        chk(name, product, exp);
`ifdef BOOTH_OVF_EN
        chk({name, "_ovf"}, ovf, exp_ovf);
`else
        if (exp_ovf === 1'bx) chk({name, "_ovfx"}, 0, 1);
`endif
    endtask

    function automatic logic [N-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(N-1){1'b0}}};
            3:       return {1'b0, {(N-1){1'b1}}};
            4:       return 1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int cyc;
        logic [N-1:0] a;
        logic [N-1:0] b;
        rst = 1'b1; start = 1'b0; mc = '0; mp = '0;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_product", product, 0);
        chk("idle_busy", busy, 0);

        run_op(7, 3, 64'h0000_0000_0000_0015, 1'b0, "m7x3");
        run_op(-5, 6, 64'hFFFF_FFFF_FFFF_FFE2, 1'b0, "m-5x6");
        run_op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1, "minxmin");
        @(negedge clk);

        // Start held high while operands change mid-run; second op launches in the done cycle.
        start = 1'b1; mc = 12; mp = -12;
        @(negedge clk);
        mc = 1; mp = 1;
        wait_done(cyc);
        chk("held_lat", cyc, N + 1);
        chk("held_first", product, 64'hFFFF_FFFF_FFFF_FF70);
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        chk("b2b_lat", cyc, N + 1);
        chk("b2b_product", product, 1);
        @(negedge clk);

        // Reset mid-run discards the operation.
        start = 1'b1; mc = 100; mp = 100;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_product", product, 0);
        repeat (N + 5) @(negedge clk);
        run_op(2, -1, -2, 1'b0, "m2x-1");

        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            a = pick();
            b = pick();
            run_op(a, b, ref_mul(a, b), ref_ovf(ref_mul(a, b)), "rand");
        end
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
